// File: rtl/bit_serializer.sv
// bit_serializer
//   Parallel-to-serial bit-stream source for the downstream sequence detector.
//   Accepts WIDTH-bit words on a valid/ready handshake and shifts them out
//   MSB-first. Each bit is held for BIT_CYCLES clocks. Words may follow each
//   other with no idle gap between them.
//
//   Optional feature: define SER_PARITY_EN to append an even-parity bit after
//   the LSB. The parity bit is held for BIT_CYCLES clocks and carries
//   frame_last.
//
// Ports
//   clk          clock, rising edge
//   reset        asynchronous, active-high reset
//   data_in      parallel word, captured on an accepted transfer
//   data_valid   upstream presents a word
//   data_ready   serializer accepts a word this cycle (0 while in reset)
//   ser_out      serial bit
//   ser_valid    ser_out carries a frame bit
//   frame_start  high for every cycle of the first bit of a frame
//   frame_last   high for every cycle of the final bit of a frame
//   busy         a frame is in progress
//
// state  | meaning
// IDLE   | no frame in flight, waiting for a word
// SHIFT  | shifting data bits out, MSB first
// PARITY | holding the even-parity bit (SER_PARITY_EN only)
module bit_serializer #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             frame_last,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int HW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
`ifdef SER_PARITY_EN
  localparam logic [1:0] PARITY = 2'd2;
`endif

  logic [1:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bit_cnt;
  logic [HW-1:0]    hold_cnt;
`ifdef SER_PARITY_EN
  logic             par_q;
`endif

  logic hold_last;
  logic bit_last;
  logic frame_end;
  logic xfer;

  // With BIT_CYCLES=1 the hold counter stays 0 and every cycle is a wrap.
  assign hold_last = (hold_cnt == HW'(BIT_CYCLES - 1));
  assign bit_last  = (bit_cnt == CW'(WIDTH - 1));

`ifdef SER_PARITY_EN
  assign frame_end = (state == PARITY) && hold_last;
`else
  assign frame_end = (state == SHIFT) && bit_last && hold_last;
`endif

  // Ready only in IDLE or in the very last cycle of a frame. This lets the
  // next word start with no bubble.
  assign data_ready = !reset && ((state == IDLE) || frame_end);
  assign xfer       = data_valid && data_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      hold_cnt <= '0;
`ifdef SER_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else if (xfer) begin
      // A transfer is only possible in IDLE or at frame end, so a reload
      // takes priority over normal sequencing.
      state    <= SHIFT;
      shreg    <= data_in;
      bit_cnt  <= '0;
      hold_cnt <= '0;
`ifdef SER_PARITY_EN
      par_q    <= ^data_in;
`endif
    end else begin
      case (state)
        SHIFT: begin
          if (hold_last) begin
            hold_cnt <= '0;
            if (bit_last) begin
`ifdef SER_PARITY_EN
              state <= PARITY;
`else
              state <= IDLE;
`endif
            end else begin
              shreg   <= shreg << 1;
              bit_cnt <= bit_cnt + CW'(1);
            end
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
`ifdef SER_PARITY_EN
        PARITY: begin
          if (hold_last) begin
            hold_cnt <= '0;
            state    <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode registered state only; there is no path from data_in or data_valid.
  always_comb begin
    ser_valid   = 1'b0;
    ser_out     = 1'b0;
    frame_start = 1'b0;
    frame_last  = 1'b0;
    if (state == SHIFT) begin
      ser_valid   = 1'b1;
      ser_out     = shreg[WIDTH-1];
      frame_start = (bit_cnt == '0);
`ifndef SER_PARITY_EN
      frame_last  = bit_last;
`endif
    end
`ifdef SER_PARITY_EN
    if (state == PARITY) begin
      ser_valid  = 1'b1;
      ser_out    = par_q;
      frame_last = 1'b1;
    end
`endif
  end

  assign busy = ser_valid;

endmodule

// File: tb/tb_bit_serializer.sv
module tb_bit_serializer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       dv  [2];
  logic [7:0] din [2];
  logic       dr  [2];
  logic       so  [2];
  logic       sv  [2];
  logic       fs  [2];
  logic       fl  [2];
  logic       bz  [2];

  int checks = 0;
  int errors = 0;

  // Expected per-cycle entries: {ser_out, frame_start, frame_last}.
  logic [2:0] q [2][$];

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .BIT_CYCLES(1)) dut0 (
    .clk(clk), .reset(reset), .data_in(din[0]), .data_valid(dv[0]),
    .data_ready(dr[0]), .ser_out(so[0]), .ser_valid(sv[0]),
    .frame_start(fs[0]), .frame_last(fl[0]), .busy(bz[0]));

  bit_serializer #(.WIDTH(8), .BIT_CYCLES(3)) dut1 (
    .clk(clk), .reset(reset), .data_in(din[1]), .data_valid(dv[1]),
    .data_ready(dr[1]), .ser_out(so[1]), .ser_valid(sv[1]),
    .frame_start(fs[1]), .frame_last(fl[1]), .busy(bz[1]));

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expand a word into the per-cycle stream the serializer must produce.
  // par is the hand-computed even parity of w.
  task automatic expect_word(input int d, input logic [7:0] w, input logic par, input int bc);
    for (int i = 7; i >= 0; i--) begin
      for (int k = 0; k < bc; k++) begin
`ifdef SER_PARITY_EN
        q[d].push_back({w[i], i == 7, 1'b0});
`else
        q[d].push_back({w[i], i == 7, i == 0});
`endif
      end
    end
`ifdef SER_PARITY_EN
    for (int k = 0; k < bc; k++) q[d].push_back({par, 1'b0, 1'b1});
`endif
  endtask

  // Offer a word; keep data_valid high afterwards when hold=1 so a
  // following send forms a back-to-back stream.
  task automatic send(input int d, input logic [7:0] w, input logic par, input logic hold);
    int n = 0;
    @(negedge clk);
    din[d] = w;
    dv[d]  = 1'b1;
    while (!dr[d] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!dr[d]) begin
      chk("send_timeout", 4'(dr[d]), 4'd1);
      dv[d] = 1'b0;
      return;
    end
    @(posedge clk);
    expect_word(d, w, par, d == 0 ? 1 : 3);
    #1;
    if (!hold) dv[d] = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && (q[0].size() != 0 || q[1].size() != 0); i++) @(negedge clk);
    chk("drain_q0_empty", 4'(q[0].size() != 0), 4'd0);
    chk("drain_q1_empty", 4'(q[1].size() != 0), 4'd0);
    repeat (2) @(negedge clk);
  endtask

  for (genvar g = 0; g < 2; g++) begin : mon
    always @(negedge clk) begin
      logic [2:0] e;
      if (!reset) begin
        chk($sformatf("ready%0d", g), 4'(dr[g]), 4'(q[g].size() <= 1));
        chk($sformatf("busy%0d", g), 4'(bz[g]), 4'(q[g].size() > 0));
        if (q[g].size() > 0) begin
          e = q[g].pop_front();
          chk($sformatf("bit%0d{v,o,s,l}", g), {sv[g], so[g], fs[g], fl[g]}, {1'b1, e});
        end else begin
          chk($sformatf("idle%0d{v,o,s,l}", g), {sv[g], so[g], fs[g], fl[g]}, 4'd0);
        end
      end
    end
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      dv[d] = 1'b0;
      din[d] = 8'h00;
    end

    // Outputs held low during reset, data_ready forced 0.
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_outs", {sv[d], so[d], fs[d], fl[d]}, 4'd0);
      chk("rst_busy_ready", {2'b00, bz[d], dr[d]}, 4'd0);
    end
    @(posedge clk); #2 reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst0", 4'(dr[0]), 4'd1);
    chk("ready_after_rst1", 4'(dr[1]), 4'd1);

    // Single word.
    send(0, 8'hB5, 1'b1, 1'b0);
    drain();

    // Back-to-back with data_valid held high.
    send(0, 8'hFF, 1'b0, 1'b1);
    send(0, 8'h00, 1'b0, 1'b0);
    drain();

    // BIT_CYCLES=3 instance.
    send(1, 8'hA0, 1'b0, 1'b0);
    drain();
    send(1, 8'h81, 1'b0, 1'b1);
    send(1, 8'h7E, 1'b0, 1'b0);
    drain();

    // Stall while busy, then data_in changes mid-frame.
    send(0, 8'h3C, 1'b0, 1'b1);
    send(0, 8'hC3, 1'b0, 1'b0);
    send(0, 8'h5A, 1'b0, 1'b0);
    repeat (4) begin
      @(negedge clk);
      din[0] = 8'($urandom);
    end
    send(0, 8'h96, 1'b0, 1'b0);
    drain();

    // Parity vectors (plain data frames when parity is not built in).
    send(0, 8'h07, 1'b1, 1'b0);
    send(0, 8'h03, 1'b0, 1'b0);
    drain();

    // Reset mid-frame discards the partial frame.
    send(0, 8'hF0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_valid_busy", {2'b00, sv[0], bz[0]}, 4'd0);
    chk("midrst_ready", 4'(dr[0]), 4'd0);
    q[0].delete();
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 4'(dr[0]), 4'd1);
    repeat (10) @(negedge clk);
    send(0, 8'hB5, 1'b1, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Parallel-to-serial bit-stream source that feeds the 1-bit `in` pin of the downstream Moore sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake.
- Shifts each word out MSB-first, one bit per BIT_CYCLES clocks, with frame markers.
- Allows back-to-back words with no idle gap, so the detector sees a continuous stream.

Parameters:
- WIDTH, 8: data word width in bits; must be >= 2.
- BIT_CYCLES, 1: clocks each serial bit is held; must be >= 1.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  WIDTH  parallel word; sampled on an accepted transfer.
- data_valid  input  1  upstream has a word on data_in.
- data_ready  output  1  serializer can accept a word this cycle.
- ser_out  output  1  serial bit; connects to the detector `in`.
- ser_valid  output  1  ser_out carries a frame bit this cycle.
- frame_start  output  1  high during every cycle of the first bit of a frame.
- frame_last  output  1  high during every cycle of the final bit of a frame.
- busy  output  1  a frame is in progress.

Behaviour:
- Reset (asynchronous):
  - state=IDLE; shift register, bit counter and hold counter cleared.
  - ser_out, ser_valid, frame_start, frame_last and busy all 0.
  - data_ready is forced 0 while reset is high.
- Transfer: occurs at a rising edge where data_valid=1 and data_ready=1 are sampled.
  - data_in is captured into the shift register on that edge.
- States: IDLE, SHIFT, PARITY (PARITY only exists with SER_PARITY_EN).
- IDLE:
  - data_ready=1; ser_valid=0, ser_out=0, busy=0.
  - On transfer -> SHIFT.
- SHIFT:
  - busy=1, ser_valid=1, ser_out = current MSB of the shift register.
  - Each bit is held exactly BIT_CYCLES cycles; the hold counter runs 0..BIT_CYCLES-1.
  - At hold wrap, the register shifts left by 1 and the bit counter increments.
  - After bit index WIDTH-1 completes:
    - With parity: -> PARITY.
    - Without parity: on a transfer in that cycle, reload and stay in SHIFT; otherwise -> IDLE.
- Latency: transfer at edge N -> first bit (data_in[WIDTH-1]) appears on ser_out in the cycle following edge N.
  - All serial outputs are registered, with no combinational path from data_in or data_valid.
- frame_start: asserted during all BIT_CYCLES cycles of bit 0 of each frame.
- frame_last: asserted during all cycles of the final bit of each frame (the parity bit when enabled).
- data_ready (combinational from state and counters): 1 in IDLE, or in the last hold cycle of the frame's final bit.
  - Otherwise 0.
- Back-to-back:
  - A transfer in the final cycle of a frame starts the next frame's MSB in the very next cycle.
  - ser_valid stays 1 with no bubble; frame_start reasserts.
- data_valid low at frame end -> ser_valid=0, ser_out=0, busy=0 in the next cycle.
- data_valid may toggle arbitrarily; words are never dropped or duplicated.
- data_in changing mid-frame has no effect on the frame already in flight.
- Reset asserted mid-frame:
  - Outputs clear immediately (asynchronously) and the partial frame is discarded.
  - After release the block sits in IDLE with data_ready=1.
- Counter widths: $clog2 of WIDTH and BIT_CYCLES, each minimum 1 bit. The BIT_CYCLES=1 case has no hold counter effect.
- Frame length in cycles: WIDTH*BIT_CYCLES, or (WIDTH+1)*BIT_CYCLES with parity.

Optional Feature:
- Macro: SER_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of all WIDTH data bits, captured at transfer) is appended after the LSB via the PARITY state.
  - It is held BIT_CYCLES cycles with ser_valid=1 and frame_last=1.
  - frame_last is not asserted on the LSB.
- Undefined:
  - No PARITY state and no parity logic.
  - The frame ends on the LSB, which carries frame_last.

Test Plan:
- Reset, then release → all outputs 0 during reset and data_ready=1 after release. Assert reset for 3 cycles mid-frame → ser_valid drops with reset, no further bits are emitted, and IDLE resumes.
- WIDTH=8, BIT_CYCLES=1, one transfer of 8'hB5 → ser_out 1,0,1,1,0,1,0,1 on cycles 1..8 with ser_valid=1; frame_start on cycle 1; frame_last on cycle 8; ser_valid=0 on cycle 9.
- Back-to-back 8'hFF then 8'h00, data_valid held high → 16 consecutive valid cycles with no gap: eight 1s then eight 0s, frame_start on cycles 1 and 9.
- BIT_CYCLES=3, word 8'hA0 → each bit held 3 cycles; 24-cycle frame with ser_out=1 for cycles 1-3 and 7-9, 0 elsewhere; data_ready high only in cycle 24.
- Stall: data_valid=1 arrives while busy → data_ready=0 until the last cycle, no word is lost, and data_in changes mid-frame do not alter the output.
- SER_PARITY_EN, 8'h07 → 8 data bits followed by parity bit 1 (9 cycles); frame_last only on the 9th; 8'h03 → parity bit 0.
